// File: rtl/gray_pkg.sv
// gray_pkg -- shared constants for the RGB-to-grayscale datapath.
// Luma weights (sum to 256), rounding constant and final right shift.
// The weights are held at WT_W bits so the shift-and-add helper can walk
// their bits directly.
package gray_pkg;

  localparam int unsigned SHIFT = 8;
  localparam int unsigned WT_W  = SHIFT;
  localparam int unsigned ROUND = 128;

  localparam logic [WT_W-1:0] W_R = 8'd77;   // 64+8+4+1
  localparam logic [WT_W-1:0] W_G = 8'd150;  // 128+16+4+2
  localparam logic [WT_W-1:0] W_B = 8'd29;   // 16+8+4+1

endpackage

// File: rtl/rgb_to_gray_pipe_adder.sv
// full_adder / ripple_adder -- carry-ripple adder built from 1-bit cells.
// full_adder : i_a, i_b, i_c -> o_s (sum), o_c (carry out)
// ripple_adder #(W) : i_a, i_b [W-1:0] -> o_sum [W-1:0] (modulo 2^W)
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module ripple_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);
  logic [W-1:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < W - 1; i++) begin : g_cell
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c[i]),
      .o_s (o_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  // The callers' sums always fit in W bits, so the top bit needs no carry out.
  assign o_sum[W-1] = i_a[W-1] ^ i_b[W-1] ^ w_c[W-1];
endmodule

// File: rtl/rgb_to_gray_pipe.sv
// rgb_to_gray_pipe -- 3-stage elastic RGB to grayscale converter.
// gray = (77*R + 150*G + 29*B + 128) >> 8
// S1: weighted terms, S2: three-term sum, S3: rounded/shifted gray.
// Ports:
//   clk, rst (sync, active-high)
//   in_r/in_g/in_b, in_last, in_valid -> in_ready   input stream
//   out_gray, out_last, out_valid <- out_ready      output stream
//   frame_cnt   frames completed at the output (wraps)
module rgb_to_gray_pipe
  import gray_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_gray,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int unsigned SUM_W = 2 * PIX_W;

  // Constant-weight multiply as a sum of shifted copies; w is a package
  // constant at every call, so this folds to a fixed adder tree.
  function automatic logic [SUM_W-1:0] weigh(input logic [PIX_W-1:0] x,
                                             input logic [WT_W-1:0] w);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < WT_W; i++) begin
      if (w[i]) acc = acc + (SUM_W'(x) << i);
    end
    return acc;
  endfunction

  logic             r_v1, r_v2, r_v3;
  logic             r_last1, r_last2, r_last3;
  logic [SUM_W-1:0] r_tr, r_tg, r_tb;
  logic [SUM_W-1:0] r_sum;
  logic [PIX_W-1:0] r_gray;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_adv1, w_adv2, w_adv3;
  logic [SUM_W-1:0] w_sum_rg, w_sum;

  // A stage advances when empty or when the stage after it advances.
  assign w_adv3   = !r_v3 || out_ready;
  assign w_adv2   = !r_v2 || w_adv3;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  ripple_adder #(.W(SUM_W)) u_add_rg (
    .i_a   (r_tr),
    .i_b   (r_tg),
    .o_sum (w_sum_rg)
  );

  ripple_adder #(.W(SUM_W)) u_add_b (
    .i_a   (w_sum_rg),
    .i_b   (r_tb),
    .o_sum (w_sum)
  );

  // Valid bits, output stage and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_last3     <= 1'b0;
      r_gray      <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_last3 <= r_last2;
          r_gray  <= PIX_W'((r_sum + SUM_W'(ROUND)) >> SHIFT);
        end
      end
      if (r_v3 && out_ready && r_last3) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  // S1/S2 payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_tr    <= weigh(in_r, W_R);
      r_tg    <= weigh(in_g, W_G);
      r_tb    <= weigh(in_b, W_B);
      r_last1 <= in_last;
    end
    if (w_adv2 && r_v1) begin
      r_sum   <= w_sum;
      r_last2 <= r_last1;
    end
  end

  assign out_gray  = r_gray;
  assign out_last  = r_last3;
  assign out_valid = r_v3;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Directed bench for rgb_to_gray_pipe: a default build and a CNT_W=4 build
// share one stimulus stream; outputs are compared to hand-computed values.
module tb_rgb_to_gray_pipe;

  logic       clk = 1'b0;
  logic       rst, in_last, in_valid, out_ready;
  logic [7:0] in_r, in_g, in_b;

  logic        in_ready, out_last, out_valid;
  logic [7:0]  out_gray;
  logic [15:0] frame_cnt;

  logic        in_ready4, out_last4, out_valid4;
  logic [7:0]  out_gray4;
  logic [3:0]  frame_cnt4;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q[$];  // {last, gray} of each output handshake (default build)

  always #5 clk = ~clk;

  rgb_to_gray_pipe #(.PIX_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_gray(out_gray), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  rgb_to_gray_pipe #(.PIX_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready4),
    .out_gray(out_gray4), .out_last(out_last4), .out_valid(out_valid4),
    .out_ready(out_ready), .frame_cnt(frame_cnt4)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({out_last, out_gray});
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b, input bit last, input bit vld);
    in_r     = 8'(r);
    in_g     = 8'(g);
    in_b     = 8'(b);
    in_last  = last;
    in_valid = vld;
  endtask

  task automatic wait_q(input int n, input int maxc);
    int k;
    k = 0;
    while (q.size() < n && k < maxc) begin
      cyc();
      k++;
    end
    chk("drain_count", q.size(), n);
  endtask

  // Hand-computed: (77R+150G+29B+128)>>8
  int v37_r[4] = '{255, 0, 0, 0};
  int v37_g[4] = '{0, 255, 0, 0};
  int v37_b[4] = '{0, 0, 255, 0};
  int e37[4]   = '{77, 149, 29, 0};   // 19763>>8, 38378>>8, 7523>>8, 128>>8

  int v38_r[10] = '{100, 10, 200, 0, 1, 128, 50, 255, 0, 3};
  int v38_g[10] = '{50, 20, 100, 128, 1, 128, 60, 255, 255, 7};
  int v38_b[10] = '{200, 30, 0, 0, 1, 128, 70, 0, 255, 11};
  int e38[10]   = '{82, 18, 119, 75, 1, 128, 58, 226, 178, 6};

  initial begin
    int idx;
    bit acc;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_cnt4", frame_cnt4, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", in_ready, 1);

    // White pixel: latency 3 cycles
    drive(255, 255, 255, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("white_lat1_valid", out_valid, 0);
    cyc();
    chk("white_lat2_valid", out_valid, 0);
    cyc();
    chk("white_lat3_valid", out_valid, 1);
    chk("white_gray", out_gray, 255);
    cyc();
    chk("white_count", q.size(), 1);
    q.delete();

    // Primaries back to back
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(v37_r[c], v37_g[c], v37_b[c], 1'b0, 1'b1);
      else in_valid = 1'b0;
      if (c >= 3 && c < 7) begin
        chk("prim_valid", out_valid, 1);
        chk("prim_gray", out_gray, e37[c-3]);
      end
      if (c == 7) chk("prim_tail_valid", out_valid, 0);
      cyc();
    end
    q.delete();

    // Ten pixels with out_ready low in cycles 4-7
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (idx < 10) drive(v38_r[idx], v38_g[idx], v38_b[idx], 1'b0, 1'b1);
      else in_valid = 1'b0;
      #1;
      if (c == 4 || c == 7) chk("stall_in_ready", in_ready, 0);
      if (c >= 4 && c <= 7) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_gray", out_gray, e38[1]);
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
    end
    out_ready = 1'b1;
    chk("stream_accepted", idx, 10);
    wait_q(10, 20);
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      chk("stream_gray", int'(q[i][7:0]), e38[i]);
      chk("stream_last", int'(q[i][8]), 0);
    end
    q.delete();

    // Two frames of four gray-equal pixels (R=G=B=v gives v)
    chk("frame_cnt_start", frame_cnt, 0);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) begin
        drive(10 * (4 * f + p + 1), 10 * (4 * f + p + 1), 10 * (4 * f + p + 1), p == 3, 1'b1);
        cyc();
      end
      in_valid = 1'b0;
      wait_q(4, 20);
      for (int i = 0; i < 4 && i < q.size(); i++) begin
        chk("frame_gray", int'(q[i][7:0]), 10 * (4 * f + i + 1));
        chk("frame_last", int'(q[i][8]), (i == 3) ? 1 : 0);
      end
      chk("frame_cnt", frame_cnt, f + 1);
      chk("frame_cnt4", frame_cnt4, f + 1);
      q.delete();
    end

    // Reset with three pixels in flight (each marked last)
    for (int p = 0; p < 3; p++) begin
      drive(90 + p, 90 + p, 90 + p, 1'b1, 1'b1);
      cyc();
    end
    chk("flight_valid", out_valid, 1);
    rst = 1'b1;
    cyc();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_frame_cnt4", frame_cnt4, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("midrst_no_stale", out_valid, 0);
    end
    chk("midrst_q_empty", q.size(), 0);
    q.delete();

    // Fifteen single-pixel frames, then one more wraps the 4-bit counter
    for (int p = 0; p < 15; p++) begin
      drive(p, p, p, 1'b1, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    wait_q(15, 40);
    chk("wrap_pre_cnt4", frame_cnt4, 15);
    chk("wrap_pre_cnt", frame_cnt, 15);
    q.delete();
    drive(200, 200, 200, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    wait_q(1, 20);
    chk("wrap_cnt4", frame_cnt4, 0);
    chk("wrap_cnt", frame_cnt, 16);
    if (q.size() > 0) chk("wrap_gray", int'(q[0][7:0]), 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
